mem_initiator: RTL and testbench

- Bus-master side of the core's memory interface.
- Accepts one load/store request at a time from the execute stage and drives the word-addressed memory port (mem_ready request / mem_valid reply, 4-bit write strobes).
- Handles byte/half/word sizing: strobe generation, write-data lane replication, read-lane extraction with sign or zero extension.
- Reports misaligned accesses without touching the bus, and times out requests the memory never answers (e.g. out-of-range addresses).

---
 rtl/mem_initiator.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_mem_initiator.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_initiator.sv
// mem_initiator: bus-master side of the core's memory interface.
// Takes one load/store at a time from the execute stage and runs it on the
// word-addressed memory port using a mem_ready request / mem_valid reply
// handshake. It generates byte strobes and replicates write data across
// lanes. On loads it extracts the addressed lane and sign- or zero-extends it.
// Misaligned requests are answered with an error and never reach the bus.
// Requests that memory never answers are abandoned after TIMEOUT cycles.

module mem_initiator #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        mem_ready,
    input  logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);

    // Counter is one bit wider than needed so the saturation value can never
    // alias the terminal count.
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // ------------------------------------------------------------------
    // Sizing helpers
    // ------------------------------------------------------------------

    // Half must be 2-byte aligned and word 4-byte aligned; the reserved size
    // is always rejected.
    function automatic logic misaligned_f(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = lo[0];
            2'b10:   bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Byte enables for a store, shifted to the addressed lane.
    function automatic logic [3:0] strb_f(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] s;
        case (size)
            2'b00:   s = 4'b0001 << lo;
            2'b01:   s = 4'b0011 << lo;
            2'b10:   s = 4'b1111;
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

    // Right-justified store data replicated into every lane it could occupy.
    function automatic logic [31:0] wdata_f(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] w;
        case (size)
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    // Pick the addressed byte or half out of the read word and extend it.
    function automatic logic [31:0] extract_f(input logic [31:0] rd, input logic [1:0] size,
                                              input logic uns, input logic [1:0] lo);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lo)
            2'b00:   b = rd[7:0];
            2'b01:   b = rd[15:8];
            2'b10:   b = rd[23:16];
            default: b = rd[31:24];
        endcase
        if (lo[1]) begin
            h = rd[31:16];
        end else begin
            h = rd[15:0];
        end
        case (size)
            2'b00: begin
                if (uns) begin
                    r = {24'h000000, b};
                end else begin
                    r = {{24{b[7]}}, b};
                end
            end
            2'b01: begin
                if (uns) begin
                    r = {16'h0000, h};
                end else begin
                    r = {{16{h[15]}}, h};
                end
            end
            default: r = rd;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------
    state_t        state_r, state_s;
    logic          wr_r, wr_s;
    logic [1:0]    size_r, size_s;
    logic          uns_r, uns_s;
    logic [1:0]    lo_r, lo_s;
    logic [CW-1:0] cnt_r, cnt_s;

    logic          resp_valid_r, resp_valid_s;
    logic [31:0]   resp_data_r, resp_data_s;
    logic          resp_err_r, resp_err_s;
    logic          mem_ready_r, mem_ready_s;
    logic [31:0]   mem_addr_r, mem_addr_s;
    logic [31:0]   mem_wdata_r, mem_wdata_s;
    logic [3:0]    mem_wstrb_r, mem_wstrb_s;

    logic          accept_s;
    logic          mis_s;
    logic          timeout_s;

    assign req_ready  = (state_r == ST_IDLE);
    assign accept_s   = req_valid && (state_r == ST_IDLE);
    assign mis_s      = misaligned_f(req_size, req_addr[1:0]);
    assign timeout_s  = (cnt_r == CNT_LAST);

    assign resp_valid = resp_valid_r;
    assign resp_data  = resp_data_r;
    assign resp_err   = resp_err_r;
    assign mem_ready  = mem_ready_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign mem_wstrb  = mem_wstrb_r;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a reply from memory beats the timeout on the same edge.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (mis_s) begin
                        state_s = ST_RESP;
                    end else begin
                        state_s = ST_BUS;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUS: begin
                if (mem_valid) begin
                    state_s = ST_RESP;
                end else if (timeout_s) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_BUS;
                end
            end
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Next values of the latched request fields, counter and registered outputs.
    always_comb begin
        wr_s         = wr_r;
        size_s       = size_r;
        uns_s        = uns_r;
        lo_s         = lo_r;
        cnt_s        = cnt_r;
        resp_valid_s = 1'b0;
        resp_data_s  = resp_data_r;
        resp_err_s   = resp_err_r;
        mem_ready_s  = mem_ready_r;
        mem_addr_s   = mem_addr_r;
        mem_wdata_s  = mem_wdata_r;
        mem_wstrb_s  = mem_wstrb_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    wr_s   = req_write;
                    size_s = req_size;
                    uns_s  = req_unsigned;
                    lo_s   = req_addr[1:0];
                    if (mis_s) begin
                        resp_valid_s = 1'b1;
                        resp_err_s   = 1'b1;
                        resp_data_s  = 32'h0000_0000;
                        mem_ready_s  = 1'b0;
                    end else begin
                        mem_ready_s = 1'b1;
                        mem_addr_s  = {req_addr[31:2], 2'b00};
                        mem_wdata_s = wdata_f(req_size, req_data);
                        if (req_write) begin
                            mem_wstrb_s = strb_f(req_size, req_addr[1:0]);
                        end else begin
                            mem_wstrb_s = 4'b0000;
                        end
                        cnt_s = {CW{1'b0}};
                    end
                end else begin
                    mem_ready_s = 1'b0;
                end
            end
            ST_BUS: begin
                if (mem_valid) begin
                    mem_ready_s  = 1'b0;
                    mem_wstrb_s  = 4'b0000;
                    resp_valid_s = 1'b1;
                    resp_err_s   = 1'b0;
                    if (wr_r) begin
                        resp_data_s = 32'h0000_0000;
                    end else begin
                        resp_data_s = extract_f(mem_rdata, size_r, uns_r, lo_r);
                    end
                end else if (timeout_s) begin
                    mem_ready_s  = 1'b0;
                    mem_wstrb_s  = 4'b0000;
                    resp_valid_s = 1'b1;
                    resp_err_s   = 1'b1;
                    resp_data_s  = 32'h0000_0000;
                end else begin
                    if (cnt_r != CNT_MAX) begin
                        cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
            end
            ST_RESP: begin
                mem_ready_s = 1'b0;
            end
            default: begin
                mem_ready_s = 1'b0;
                mem_wstrb_s = 4'b0000;
            end
        endcase
    end

    // Output and datapath registers; reset drops the bus request and any
    // pending response.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_r         <= 1'b0;
            size_r       <= 2'b00;
            uns_r        <= 1'b0;
            lo_r         <= 2'b00;
            cnt_r        <= {CW{1'b0}};
            resp_valid_r <= 1'b0;
            resp_data_r  <= 32'h0000_0000;
            resp_err_r   <= 1'b0;
            mem_ready_r  <= 1'b0;
            mem_addr_r   <= 32'h0000_0000;
            mem_wdata_r  <= 32'h0000_0000;
            mem_wstrb_r  <= 4'b0000;
        end else begin
            wr_r         <= wr_s;
            size_r       <= size_s;
            uns_r        <= uns_s;
            lo_r         <= lo_s;
            cnt_r        <= cnt_s;
            resp_valid_r <= resp_valid_s;
            resp_data_r  <= resp_data_s;
            resp_err_r   <= resp_err_s;
            mem_ready_r  <= mem_ready_s;
            mem_addr_r   <= mem_addr_s;
            mem_wdata_r  <= mem_wdata_s;
            mem_wstrb_r  <= mem_wstrb_s;
        end
    end

endmodule

// File: tb/tb_mem_initiator.sv
// Testbench for mem_initiator: a small behavioural memory with programmable
// reply latency, a directed vector table, hand-written corner sequences and
// randomized requests checked against a byte-level reference model.

module tb_mem_initiator;

    localparam int MEM_WORDS = 256;
    localparam int MEM_BYTES = MEM_WORDS * 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        mem_ready;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = 32'h0;

    int n_vec  = 0;
    int n_miss = 0;

    // Memory model state
    logic [31:0] mem [MEM_WORDS];
    logic        mem_init;
    int          mem_lat = 1;
    int          wait_cnt = 0;
    int          acc_count = 0;

    // Reference model storage
    logic [31:0] ref_mem [MEM_WORDS];

    mem_initiator #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_data(req_data), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_err(resp_err), .mem_ready(mem_ready), .mem_valid(mem_valid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int i);
        return 32'hC3A5_0000 ^ (i * 32'h0103_0507);
    endfunction

    // Memory: acts on the mem_latth consecutive cycle of mem_ready; ignores
    // mem_ready during its own reply cycle; never answers out-of-range.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= pat(i);
            mem_valid <= 1'b0;
            wait_cnt  <= 0;
        end else begin
            mem_valid <= 1'b0;
            if (mem_ready && !mem_valid) begin
                if (wait_cnt + 1 >= mem_lat) begin
                    wait_cnt <= 0;
                    if (mem_addr < MEM_BYTES) begin
                        for (int k = 0; k < 4; k++)
                            if (mem_wstrb[k]) mem[mem_addr[9:2]][8*k +: 8] <= mem_wdata[8*k +: 8];
                        mem_rdata <= mem[mem_addr[9:2]];
                        mem_valid <= 1'b1;
                        acc_count <= acc_count + 1;
                    end
                end else begin
                    wait_cnt <= wait_cnt + 1;
                end
            end else begin
                wait_cnt <= 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    // Reference model: derives the response purely from byte arithmetic on ref_mem.
    task automatic model(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] data,
                         output logic [31:0] e_data, output logic e_err, output int e_lat,
                         output int e_rdy, output int e_acc, output logic [3:0] e_strb,
                         output logic [31:0] e_wdata);
        int  nb;
        logic mis, inr;
        logic [31:0] a;
        nb  = 1 << sz;
        mis = (sz == 2'd3) || ((addr % nb) != 0);
        inr = addr < MEM_BYTES;
        e_data = 32'h0; e_strb = 4'h0; e_wdata = 32'h0;
        for (int k = 0; k < 4; k++) e_wdata[8*k +: 8] = data[8*(k % nb) +: 8];
        if (wr && !mis) for (int b = 0; b < nb; b++) e_strb[(addr % 4) + b] = 1'b1;
        if (mis) begin
            e_err = 1'b1; e_lat = 0; e_rdy = 0; e_acc = 0;
        end else if (!inr) begin
            e_err = 1'b1; e_lat = 16; e_rdy = 16; e_acc = 0;
        end else begin
            e_err = 1'b0; e_lat = 2; e_rdy = 2; e_acc = 1;
            for (int b = 0; b < nb; b++) begin
                a = addr + b;
                if (wr) ref_mem[a[9:2]][8*a[1:0] +: 8] = data[8*b +: 8];
                else    e_data[8*b +: 8] = ref_mem[a[9:2]][8*a[1:0] +: 8];
            end
            if (!wr && !uns && nb < 4 && e_data[8*nb-1])
                e_data = e_data | ~((32'h1 << (8*nb)) - 32'h1);
        end
    endtask

    // Issue one request and observe the whole transaction.
    task automatic run_req(input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] data,
                           output logic [31:0] rdata, output logic err, output int lat,
                           output int rdy, output logic [3:0] strb, output logic [31:0] wdata,
                           output logic [31:0] maddr, output int acc, output logic pulse_ok);
        int  acc0;
        logic got;
        for (int c = 0; c < 40 && !req_ready; c++) begin @(posedge clk); #1; end
        check("req_ready before request", {31'b0, req_ready}, 32'h1);
        req_write = wr; req_size = sz; req_unsigned = uns; req_addr = addr; req_data = data;
        req_valid = 1'b1;
        acc0 = acc_count;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rdata = 32'h0; err = 1'b0; lat = 0; rdy = 0; strb = 4'h0; wdata = 32'h0; maddr = 32'h0;
        got = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (mem_ready) begin
                if (rdy == 0) begin strb = mem_wstrb; wdata = mem_wdata; maddr = mem_addr; end
                rdy++;
            end
            if (resp_valid) begin got = 1'b1; rdata = resp_data; err = resp_err; break; end
            @(posedge clk); #1;
            lat++;
        end
        if (!got) lat = -1;
        @(posedge clk); #1;
        pulse_ok = !resp_valid;
        acc = acc_count - acc0;
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] e_data;
        logic        e_err;
        int          e_lat;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t vt [16];

    initial begin
        logic [31:0] rdata, wdata, maddr, m_data, m_wdata, old_word;
        logic        err, pulse_ok, m_err;
        logic [3:0]  strb, m_strb;
        int          lat, rdy, acc, m_lat, m_rdy, m_acc, seen;
        logic        wr, uns;
        logic [1:0]  sz;
        logic [31:0] addr, data;

        //              wr    sz    uns   addr          data          e_data        err  lat strb     wdata
        vt[0]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0040, 32'h8899_AABB, 32'h0000_0000, 1'b0, 2, 4'b1111, 32'h8899_AABB};
        vt[1]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0041, 32'h0,         32'hFFFF_FFAA, 1'b0, 2, 4'b0000, 32'h0};
        vt[2]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0042, 32'h0,         32'h0000_8899, 1'b0, 2, 4'b0000, 32'h0};
        vt[3]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0,         32'h8899_AABB, 1'b0, 2, 4'b0000, 32'h0};
        vt[4]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0043, 32'h0000_005A, 32'h0000_0000, 1'b0, 2, 4'b1000, 32'h5A5A_5A5A};
        vt[5]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0,         32'h5A99_AABB, 1'b0, 2, 4'b0000, 32'h0};
        vt[6]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0041, 32'h0,         32'h0000_0000, 1'b1, 0, 4'b0000, 32'h0};
        vt[7]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0042, 32'h0,         32'h0000_0000, 1'b1, 0, 4'b0000, 32'h0};
        vt[8]  = '{1'b0, 2'd3, 1'b0, 32'h0000_0040, 32'h0,         32'h0000_0000, 1'b1, 0, 4'b0000, 32'h0};
        vt[9]  = '{1'b0, 2'd2, 1'b0, 32'h0002_0000, 32'h0,         32'h0000_0000, 1'b1, 16, 4'b0000, 32'h0};
        vt[10] = '{1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0,         32'h5A99_AABB, 1'b0, 2, 4'b0000, 32'h0};
        vt[11] = '{1'b1, 2'd1, 1'b0, 32'h0000_0046, 32'h0000_1234, 32'h0000_0000, 1'b0, 2, 4'b1100, 32'h1234_1234};
        vt[12] = '{1'b1, 2'd1, 1'b0, 32'h0000_0044, 32'hFFFF_BEEF, 32'h0000_0000, 1'b0, 2, 4'b0011, 32'hBEEF_BEEF};
        vt[13] = '{1'b0, 2'd1, 1'b0, 32'h0000_0046, 32'h0,         32'h0000_1234, 1'b0, 2, 4'b0000, 32'h0};
        vt[14] = '{1'b0, 2'd1, 1'b0, 32'h0000_0044, 32'h0,         32'hFFFF_BEEF, 1'b0, 2, 4'b0000, 32'h0};
        vt[15] = '{1'b0, 2'd0, 1'b1, 32'h0000_0043, 32'h0,         32'h0000_005A, 1'b0, 2, 4'b0000, 32'h0};

        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = pat(i);
        reset = 1'b1; mem_init = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'h0; req_data = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset req_ready", {31'b0, req_ready}, 32'h1);
        check("reset resp_valid", {31'b0, resp_valid}, 32'h0);
        check("reset resp_err", {31'b0, resp_err}, 32'h0);
        check("reset resp_data", resp_data, 32'h0);
        check("reset mem_ready", {31'b0, mem_ready}, 32'h0);
        check("reset mem_addr", mem_addr, 32'h0);
        check("reset mem_wdata", mem_wdata, 32'h0);
        check("reset mem_wstrb", {28'b0, mem_wstrb}, 32'h0);
        reset = 1'b0; mem_init = 1'b0;
        @(posedge clk); #1;

        // Directed vector table (1-cycle memory)
        for (int i = 0; i < 16; i++) begin
            run_req(vt[i].wr, vt[i].sz, vt[i].uns, vt[i].addr, vt[i].data,
                    rdata, err, lat, rdy, strb, wdata, maddr, acc, pulse_ok);
            model(vt[i].wr, vt[i].sz, vt[i].uns, vt[i].addr, vt[i].data,
                  m_data, m_err, m_lat, m_rdy, m_acc, m_strb, m_wdata);
            check($sformatf("vec%0d resp_data", i), rdata, vt[i].e_data);
            check($sformatf("vec%0d resp_err", i), {31'b0, err}, {31'b0, vt[i].e_err});
            check($sformatf("vec%0d latency", i), lat, vt[i].e_lat);
            check($sformatf("vec%0d mem_ready cycles", i), rdy, vt[i].e_lat);
            check($sformatf("vec%0d accesses", i), acc, (vt[i].e_lat == 2) ? 1 : 0);
            check($sformatf("vec%0d single pulse", i), {31'b0, pulse_ok}, 32'h1);
            if (rdy > 0) begin
                check($sformatf("vec%0d mem_addr", i), maddr, {vt[i].addr[31:2], 2'b00});
                check($sformatf("vec%0d mem_wstrb", i), {28'b0, strb}, {28'b0, vt[i].e_strb});
                if (vt[i].wr) check($sformatf("vec%0d mem_wdata", i), wdata, vt[i].e_wdata);
            end
        end

        // Reply arriving on the terminal-count edge wins over the timeout
        mem_lat = 15;
        run_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, rdata, err, lat, rdy, strb, wdata, maddr, acc, pulse_ok);
        check("late reply resp_err", {31'b0, err}, 32'h0);
        check("late reply resp_data", rdata, 32'h5A99_AABB);
        check("late reply latency", lat, 16);

        // Reply one cycle too late: timeout, stale mem_valid in RESP ignored
        mem_lat = 16;
        run_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, rdata, err, lat, rdy, strb, wdata, maddr, acc, pulse_ok);
        check("too late resp_err", {31'b0, err}, 32'h1);
        check("too late resp_data", rdata, 32'h0);
        check("too late latency", lat, 16);
        check("too late single pulse", {31'b0, pulse_ok}, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        check("stale reply ignored", {31'b0, resp_valid}, 32'h0);

        // Reset one cycle after accepting a store, before memory samples
        mem_lat = 3;
        old_word = ref_mem[32];
        req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h80; req_data = ~old_word; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("store accepted", {31'b0, mem_ready}, 32'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("reset mid-op mem_ready", {31'b0, mem_ready}, 32'h0);
        check("reset mid-op req_ready", {31'b0, req_ready}, 32'h1);
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (resp_valid) seen++;
            @(posedge clk); #1;
        end
        check("reset mid-op no resp_valid", seen, 0);
        mem_lat = 1;
        run_req(1'b0, 2'd2, 1'b0, 32'h80, 32'h0, rdata, err, lat, rdy, strb, wdata, maddr, acc, pulse_ok);
        check("reset mid-op word unchanged", rdata, old_word);
        check("reset mid-op readback err", {31'b0, err}, 32'h0);

        // Randomized requests against the reference model
        for (int i = 0; i < 150; i++) begin
            wr  = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            uns = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 11) == 0) addr = 32'h0001_0000 + 32'($urandom_range(0, 255));
            else                           addr = 32'($urandom_range(0, MEM_BYTES - 1));
            data = $urandom;
            run_req(wr, sz, uns, addr, data, rdata, err, lat, rdy, strb, wdata, maddr, acc, pulse_ok);
            model(wr, sz, uns, addr, data, m_data, m_err, m_lat, m_rdy, m_acc, m_strb, m_wdata);
            check($sformatf("rnd%0d resp_data", i), rdata, m_data);
            check($sformatf("rnd%0d resp_err", i), {31'b0, err}, {31'b0, m_err});
            check($sformatf("rnd%0d latency", i), lat, m_lat);
            check($sformatf("rnd%0d mem_ready cycles", i), rdy, m_rdy);
            check($sformatf("rnd%0d accesses", i), acc, m_acc);
            check($sformatf("rnd%0d single pulse", i), {31'b0, pulse_ok}, 32'h1);
            if (rdy > 0) begin
                check($sformatf("rnd%0d mem_addr", i), maddr, {addr[31:2], 2'b00});
                check($sformatf("rnd%0d mem_wstrb", i), {28'b0, strb}, {28'b0, m_strb});
                if (wr) check($sformatf("rnd%0d mem_wdata", i), wdata, m_wdata);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
